fifo_stream_reader: RTL

- Read-side master for `syncfifo`. It drains the FIFO through its `i_rd`/`o_data`/`o_empty` port and presents the words as a valid/ready stream.
- A 2-entry skid buffer absorbs the FIFO's 1-cycle read latency and consumer backpressure. The FIFO is never underflowed, no word is dropped, and throughput is 1 word/clk when the consumer is always ready.
- A burst counter marks every BURST_LEN-th word with `o_last`, so downstream packetizers get frame boundaries.

---
 rtl/fifo_stream_reader.sv | 81 ++++++++
 1 files changed

// File: rtl/fifo_stream_reader.sv
// Read-side master for a synchronous FIFO: drains it into a 2-entry skid buffer and
// presents the words as a valid/ready stream with burst framing (o_last / o_burst_idx).
module fifo_stream_reader #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BURST_LEN  = 4,
  parameter int unsigned BCNT_WIDTH = $clog2(BURST_LEN) + 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_fifo_empty,
  input  logic [DATA_WIDTH-1:0] i_fifo_data,
  output logic                  o_fifo_rd,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_last,
  input  logic                  i_ready,
  output logic [BCNT_WIDTH-1:0] o_burst_idx,
  output logic [1:0]            o_level
);

  localparam logic [BCNT_WIDTH-1:0] BcntMax = BCNT_WIDTH'(BURST_LEN - 1);

  logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
  logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
  logic [1:0]            occ_q, occ_d;
  logic [1:0]            occ_after_pop;
  logic [1:0]            committed;
  logic                  inflight_q;
  logic [BCNT_WIDTH-1:0] bcnt_q, bcnt_d;
  logic                  pop;

  assign o_valid     = (occ_q != 2'd0);
  assign o_last      = o_valid & (bcnt_q == BcntMax);
  assign o_data      = buf0_q;
  assign o_burst_idx = bcnt_q;
  assign o_level     = occ_q;

  always_comb begin
    pop           = o_valid & i_ready;
    occ_after_pop = occ_q - {1'b0, pop};
    // Slots already spoken for next cycle; a new read is only issued if one stays free.
    committed     = occ_after_pop + {1'b0, inflight_q};
    o_fifo_rd     = i_rst_n & ~i_fifo_empty & (committed < 2'd2);
    occ_d         = committed;

    buf0_d = buf0_q;
    buf1_d = buf1_q;
    if (pop) begin
      buf0_d = buf1_q;
    end
    if (inflight_q) begin
      if (occ_after_pop == 2'd0) begin
        buf0_d = i_fifo_data;
      end else begin
        buf1_d = i_fifo_data;
      end
    end

    bcnt_d = bcnt_q;
    if (pop) begin
      bcnt_d = (bcnt_q == BcntMax) ? '0 : bcnt_q + BCNT_WIDTH'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      buf0_q     <= '0;
      buf1_q     <= '0;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      bcnt_q     <= '0;
    end else begin
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      occ_q      <= occ_d;
      inflight_q <= o_fifo_rd;
      bcnt_q     <= bcnt_d;
    end
  end

endmodule
